// File: rtl/sap1_prog_loader_pkg.sv
// sap1_prog_loader shared types and default widths.
// State enum covers the optional checksum state as well.
package sap1_prog_pkg;

   localparam int SAP1_ADDR_W = 4;
   localparam int SAP1_DATA_W = 8;
   localparam int SAP1_CHK_W  = SAP1_DATA_W;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_WAIT,
      ADDR_SEND,
      DATA_WAIT,
      DATA_LOAD,
      CHK_WAIT,
      FINISH,
      ABORT
   } state_t;

endpackage

// File: rtl/sap1_prog_loader_if.sv
// Byte-stream valid/ready link feeding the program loader.
// master = host side, slave = loader side.
interface sap1_prog_loader_if
   import sap1_prog_pkg::*;
#(
   parameter int DATA_W = SAP1_DATA_W
);

   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              s_ready;

   modport master (
      output s_valid,
      output s_data,
      output s_last,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      input  s_last,
      output s_ready
   );

endinterface

// File: rtl/sap1_prog_loader_strobe_timer.sv
// Down-counter shared by the address and data strobes.
// active while counting, last on the final counted cycle.
module strobe_timer #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic active,
   output logic last
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);

   logic [CW-1:0] cnt;

   // load on start, then count down to zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= CW'(HOLD_CYCLES);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign active = (cnt != '0);
   assign last   = (cnt == CW'(1));

endmodule

// File: rtl/sap1_prog_loader.sv
// SAP-1 program loader: (address, data) byte records -> CPU port.
// Optional trailing checksum byte: SAP1_PROG_LOADER_CHECKSUM_EN.
module sap1_prog_loader
   import sap1_prog_pkg::*;
#(
   parameter int ADDR_W      = SAP1_ADDR_W,
   parameter int DATA_W      = SAP1_DATA_W,
   parameter int HOLD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   sap1_prog_loader_if.slave bus,
   output logic              pr_mode,
   output logic [ADDR_W-1:0] pr_address,
   output logic [DATA_W-1:0] pr_data,
   output logic              address_send,
   output logic              instr_load,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   rec_count
);

   localparam logic [ADDR_W:0] REC_MAX =
      {1'b1, {ADDR_W{1'b0}}};

`ifdef SAP1_PROG_LOADER_CHECKSUM_EN
   localparam state_t END_ST = CHK_WAIT;
   logic [SAP1_CHK_W-1:0] sum_q;
`else
   localparam state_t END_ST = FINISH;
`endif

   state_t state_q;
   state_t state_d;
   logic   accept;
   logic   addr_bad;
   logic   tmr_start;
   logic   tmr_active;
   logic   tmr_last;
   logic   last_q;

   assign bus.s_ready = (state_q == ADDR_WAIT) ||
                        (state_q == DATA_WAIT) ||
                        (state_q == CHK_WAIT);

   assign accept = bus.s_valid && bus.s_ready;

   assign addr_bad = bus.s_last ||
                     (|bus.s_data[DATA_W-1:ADDR_W]) ||
                     (rec_count == REC_MAX);

   assign tmr_start = accept &&
      (((state_q == ADDR_WAIT) && !addr_bad) ||
       (state_q == DATA_WAIT));

   strobe_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .start (tmr_start),
      .active(tmr_active),
      .last  (tmr_last)
   );

   assign address_send = (state_q == ADDR_SEND) && tmr_active;
   assign instr_load   = (state_q == DATA_LOAD) && tmr_active;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = ADDR_WAIT;
         end
         ADDR_WAIT: begin
            if (accept)
               state_d = addr_bad ? ABORT : ADDR_SEND;
         end
         ADDR_SEND: begin
            if (tmr_last) state_d = DATA_WAIT;
         end
         DATA_WAIT: begin
            if (accept) state_d = DATA_LOAD;
         end
         DATA_LOAD: begin
            if (tmr_last)
               state_d = last_q ? END_ST : ADDR_WAIT;
         end
         CHK_WAIT: begin
`ifdef SAP1_PROG_LOADER_CHECKSUM_EN
            if (accept)
               state_d = (bus.s_data == sum_q) ?
                         FINISH : ABORT;
`else
            state_d = IDLE;
`endif
         end
         FINISH:  state_d = IDLE;
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // session flags, latched bus values and record count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pr_mode    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         rec_count  <= '0;
         pr_address <= '0;
         pr_data    <= '0;
         last_q     <= 1'b0;
      end else begin
         if ((state_q == IDLE) && start) begin
            pr_mode   <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rec_count <= '0;
         end
         if (accept && (state_q == ADDR_WAIT) && !addr_bad)
            pr_address <= bus.s_data[ADDR_W-1:0];
         if (accept && (state_q == DATA_WAIT)) begin
            pr_data <= bus.s_data;
            last_q  <= bus.s_last;
         end
         if ((state_q == DATA_LOAD) && tmr_last)
            rec_count <= rec_count + (ADDR_W+1)'(1);
         if (state_d == FINISH) begin
            done    <= 1'b1;
            pr_mode <= 1'b0;
            busy    <= 1'b0;
         end
         if (state_d == ABORT) begin
            err     <= 1'b1;
            pr_mode <= 1'b0;
            busy    <= 1'b0;
         end
      end
   end

`ifdef SAP1_PROG_LOADER_CHECKSUM_EN
   // running sum of every address and data byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         sum_q <= '0;
      end else if (accept &&
                   ((state_q == ADDR_WAIT) ||
                    (state_q == DATA_WAIT))) begin
         sum_q <= sum_q + SAP1_CHK_W'(bus.s_data);
      end
   end
`endif

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Self-checking bench for sap1_prog_loader.
// Random records vs. a record-level reference model.
module tb_sap1_prog_loader;

   localparam int HOLD = 2;
`ifdef SAP1_PROG_LOADER_CHECKSUM_EN
   localparam int LAT = 13;
`else
   localparam int LAT = 12;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       pr_mode;
   logic [3:0] pr_address;
   logic [7:0] pr_data;
   logic       address_send;
   logic       instr_load;
   logic       busy;
   logic       done;
   logic       err;
   logic [4:0] rec_count;

   sap1_prog_loader_if bus ();

   sap1_prog_loader #(
      .ADDR_W(4),
      .DATA_W(8),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .bus         (bus),
      .pr_mode     (pr_mode),
      .pr_address  (pr_address),
      .pr_data     (pr_data),
      .address_send(address_send),
      .instr_load  (instr_load),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .rec_count   (rec_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc++;

   task automatic chk(string tag,
                      logic [31:0] got,
                      logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
      end
   endtask

   // stimulus records and model results
   logic [7:0]  rec_a[$];
   logic [7:0]  rec_d[$];
   int          last_on_addr;
   logic [11:0] exp_q[$];
   logic [11:0] obs_q[$];
   int          e_cnt;
   bit          e_done;
   bit          e_err;
   logic [7:0]  e_sum;

   // CPU-side monitor
   int         as_n = 0;
   int         il_n = 0;
   int         as_total = 0;
   logic [3:0] cur_a = '0;
   logic [7:0] cur_d = '0;
   int         t_done = 0;
   bit         done_prev = 1'b0;
   bit         first_acc;
   int         t_first = 0;

   always @(negedge clk) begin
      if (!rst) begin
         as_n = 0;
         il_n = 0;
      end else begin
         if (address_send || instr_load)
            chk("excl", {31'b0, address_send & instr_load}, 0);
         if (address_send) begin
            if (as_n == 0) begin
               cur_a = pr_address;
               as_total++;
            end else begin
               chk("addr_hold", {28'b0, pr_address}, {28'b0, cur_a});
            end
            as_n++;
         end else if (as_n != 0) begin
            chk("as_width", as_n, HOLD);
            as_n = 0;
         end
         if (instr_load) begin
            if (il_n == 0) begin
               cur_d = pr_data;
               obs_q.push_back({cur_a, pr_data});
            end else begin
               chk("data_hold", {24'b0, pr_data}, {24'b0, cur_d});
            end
            il_n++;
         end else if (il_n != 0) begin
            chk("il_width", il_n, HOLD);
            il_n = 0;
         end
         if (done && !done_prev) t_done = cyc;
         done_prev = done;
      end
   end

   // record-level reference: writes, count and outcome
   task automatic model(bit bad);
      logic [7:0] a;
      exp_q.delete();
      e_cnt  = 0;
      e_done = 1'b0;
      e_err  = 1'b0;
      e_sum  = '0;
      for (int i = 0; i < rec_a.size(); i++) begin
         a = rec_a[i];
         if (i == last_on_addr || a > 8'd15 || e_cnt == 16) begin
            e_err = 1'b1;
            return;
         end
         exp_q.push_back({a[3:0], rec_d[i]});
         e_cnt++;
         e_sum = e_sum + a + rec_d[i];
      end
`ifdef SAP1_PROG_LOADER_CHECKSUM_EN
      e_done = !bad;
      e_err  = bad;
`else
      e_done = 1'b1;
      e_err  = 1'b0;
`endif
   endtask

   task automatic send_byte(logic [7:0] d, bit l,
                            int maxgap, bit midstart);
      int n;
      if (done || err) return;
      repeat ($urandom_range(0, maxgap)) begin
         bus.s_valid = 1'b0;
         if (midstart && busy && $urandom_range(0, 2) == 0)
            start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      if (done || err) return;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      n = 0;
      while (!bus.s_ready && !err && !done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk("ready_timeout", 1, 0);
      end else if (bus.s_ready) begin
         if (first_acc) begin
            t_first   = cyc;
            first_acc = 1'b0;
         end
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_mode", {31'b0, pr_mode}, 1);
      chk("start_ready", {31'b0, bus.s_ready}, 1);
      chk("start_cnt", {27'b0, rec_count}, 0);
   endtask

   task automatic run_session(int maxgap, bit bad,
                              bit midstart, bit timing);
      int n;
      int nrec;
      model(bad);
      obs_q.delete();
      as_total  = 0;
      first_acc = 1'b1;
      nrec      = rec_a.size();
      do_start();
      for (int i = 0; i < nrec; i++) begin
         send_byte(rec_a[i], i == last_on_addr, maxgap, midstart);
         send_byte(rec_d[i], i == nrec - 1, maxgap, midstart);
      end
`ifdef SAP1_PROG_LOADER_CHECKSUM_EN
      send_byte(bad ? e_sum + 8'd1 : e_sum,
                1'($urandom_range(0, 1)), maxgap, midstart);
`endif
      n = 0;
      while (!(done || err) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("end_timeout", 1, 0);
      chk("end_mode", {31'b0, pr_mode}, 0);
      chk("end_busy", {31'b0, busy}, 0);
      @(negedge clk);
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("err", {31'b0, err}, {31'b0, e_err});
      chk("rec_count", {27'b0, rec_count}, e_cnt);
      chk("as_count", as_total, e_cnt);
      chk("n_writes", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < obs_q.size())
            chk("write", {20'b0, obs_q[i]}, {20'b0, exp_q[i]});
      if (timing) chk("finish_lat", t_done - t_first, LAT);
   endtask

   initial begin
      int nr;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mode", {31'b0, pr_mode}, 0);
      chk("rst_ready", {31'b0, bus.s_ready}, 0);
      chk("rst_as", {31'b0, address_send}, 0);
      chk("rst_il", {31'b0, instr_load}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_err", {31'b0, err}, 0);
      chk("rst_addr", {28'b0, pr_address}, 0);
      chk("rst_data", {24'b0, pr_data}, 0);
      chk("rst_cnt", {27'b0, rec_count}, 0);
      rst = 1'b1;

      // two-record program, no stalls
      rec_a = '{8'h00, 8'h01};
      rec_d = '{8'h1A, 8'h2B};
      last_on_addr = -1;
      run_session(0, 1'b0, 1'b0, 1'b1);

      // address out of range
      rec_a = '{8'h15};
      rec_d = '{8'h33};
      run_session(0, 1'b0, 1'b0, 1'b0);

      // s_last on an address byte
      rec_a = '{8'h04, 8'h05};
      rec_d = '{8'h44, 8'h55};
      last_on_addr = 0;
      run_session(0, 1'b0, 1'b0, 1'b0);

      // 17 records overflow the 16-entry RAM
      rec_a.delete();
      rec_d.delete();
      last_on_addr = -1;
      for (int i = 0; i < 17; i++) begin
         rec_a.push_back(8'(i % 16));
         rec_d.push_back(8'($urandom_range(0, 255)));
      end
      run_session(1, 1'b0, 1'b0, 1'b0);

      // first program again under backpressure and stray starts
      rec_a = '{8'h00, 8'h01};
      rec_d = '{8'h1A, 8'h2B};
      run_session(3, 1'b0, 1'b1, 1'b0);

      // random programs
      for (int s = 0; s < 8; s++) begin
         rec_a.delete();
         rec_d.delete();
         nr = $urandom_range(1, 8);
         for (int i = 0; i < nr; i++) begin
            if ($urandom_range(0, 9) == 0)
               rec_a.push_back(8'($urandom_range(16, 255)));
            else
               rec_a.push_back(8'($urandom_range(0, 15)));
            rec_d.push_back(8'($urandom_range(0, 255)));
         end
         last_on_addr = ($urandom_range(0, 5) == 0) ?
                        $urandom_range(0, nr - 1) : -1;
         run_session(3, 1'(s % 3 == 2), 1'b1, 1'b0);
      end

`ifdef SAP1_PROG_LOADER_CHECKSUM_EN
      rec_a = '{8'h03};
      rec_d = '{8'h40};
      last_on_addr = -1;
      run_session(0, 1'b0, 1'b0, 1'b0);
      run_session(0, 1'b1, 1'b0, 1'b0);
`endif

      // reset during the data strobe
      rec_a = '{8'h05};
      rec_d = '{8'h77};
      last_on_addr = -1;
      first_acc = 1'b1;
      do_start();
      send_byte(8'h05, 1'b0, 0, 1'b0);
      send_byte(8'h77, 1'b1, 0, 1'b0);
      nr = 0;
      while (!instr_load && nr < 20) begin
         @(negedge clk);
         nr++;
      end
      chk("il_seen", {31'b0, instr_load}, 1);
      #1 rst = 1'b0;
      #1;
      chk("ar_mode", {31'b0, pr_mode}, 0);
      chk("ar_as", {31'b0, address_send}, 0);
      chk("ar_il", {31'b0, instr_load}, 0);
      chk("ar_busy", {31'b0, busy}, 0);
      chk("ar_ready", {31'b0, bus.s_ready}, 0);
      chk("ar_done", {31'b0, done}, 0);
      chk("ar_err", {31'b0, err}, 0);
      chk("ar_cnt", {27'b0, rec_count}, 0);
      chk("ar_addr", {28'b0, pr_address}, 0);
      chk("ar_data", {24'b0, pr_data}, 0);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;

      // loader recovers after reset
      rec_a = '{8'h0E, 8'h02};
      rec_d = '{8'hC3, 8'h9D};
      run_session(0, 1'b0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
